// File: rtl/apb_slave_pkg.sv
// Shared types, default parameters and decode helper for the APB completer.
// Imported by apb_modport_slave and apb_regfile.
package apb_slave_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_REGS   = 16;
    localparam logic [31:0] DEF_ID_VALUE   = 32'hA9B0_0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Index 0 holds the read-only ID word, so any write aimed at it is an error.
    function automatic logic decodeError(input logic [1:0] byteOffset,
                                         input logic       indexOutOfRange,
                                         input logic       isWrite,
                                         input logic       isIndexZero);
        return (byteOffset != 2'b00) | indexOutOfRange | (isWrite & isIndexZero);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word register bank with asynchronous reset and a combinational read port.
// Word 0 always reads back ID_VALUE and ignores writes.
module apb_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned          NUM_REGS   = DEF_NUM_REGS,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = DATA_WIDTH'(DEF_ID_VALUE),
    parameter int unsigned          IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (widx_i != '0) && (32'(widx_i) < NUM_REGS)) begin
            regs_q[widx_i] <= wdata_i;
        end
    end

    // Out-of-range indices are possible when NUM_REGS is not a power of two.
    always_comb begin
        rdata_o = '0;
        if (ridx_i == '0) begin
            rdata_o = ID_VALUE;
        end else if (32'(ridx_i) < NUM_REGS) begin
            rdata_o = regs_q[ridx_i];
        end
    end

endmodule

// File: rtl/apb_modport_slave.sv
// APB completer: setup/access FSM with programmable wait states, address
// decode with error signalling, and a small register bank behind it.
module apb_modport_slave
    import apb_slave_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned           NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEF_ID_VALUE)
) (
    input  logic                  clk,
    input  logic                  preset_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-3:0] NumRegsLimit = (ADDR_WIDTH-2)'(NUM_REGS);

    apb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_WIDTH-3:0]  wordIdx;
    logic                   decErr;
    logic                   writeEn;
    logic [DATA_WIDTH-1:0]  regRdata;

    assign wordIdx = paddr[ADDR_WIDTH-1:2];
    assign decErr  = decodeError(paddr[1:0], (wordIdx >= NumRegsLimit), pwrite,
                                 (wordIdx == '0));

    assign pready  = (state_q == ACCESS) & psel & penable & (cnt_q == '0);
    assign pslverr = pready & decErr;
    assign prdata  = (pready & ~pwrite & ~decErr) ? regRdata : '0;
    assign writeEn = pready & pwrite & ~decErr;

    // Dropping psel in ACCESS is a requester abort; penable alone in IDLE is ignored.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else if (penable) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (preset_n),
        .we_i    (writeEn),
        .widx_i  (wordIdx[IDX_W-1:0]),
        .wdata_i (pwdata),
        .ridx_i  (wordIdx[IDX_W-1:0]),
        .rdata_o (regRdata)
    );

endmodule

// File: tb/tb_apb_modport_slave.sv
// Self-checking bench for apb_modport_slave: one instance with no wait states
// and one with three, driven by table vectors and hand-written corner sequences.
module tb_apb_modport_slave;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expErr;
        logic [31:0] expData;
        string       name;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk;
    logic        preset_n;
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    int   checks;
    int   errors;
    vec_t vecs[$];
    exp_t sb[$];

    apb_modport_slave #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .preset_n(preset_n), .paddr(paddr[0]), .pwrite(pwrite[0]),
        .psel(psel[0]), .penable(penable[0]), .pwdata(pwdata[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_modport_slave #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .preset_n(preset_n), .paddr(paddr[1]), .pwrite(pwrite[1]),
        .psel(psel[1]), .penable(penable[1]), .pwdata(pwdata[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Full transfer; expected response goes into the scoreboard at setup and is
    // popped when pready appears. Returns with the completion cycle still driven.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic expErr,
                                 input logic [31:0] expData, input string name);
        int   waited;
        bit   done;
        exp_t e;
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = data;
        sb.push_back('{expErr, expData, name});
        @(negedge clk);
        checkOutput({name, "_setup_pready"}, 32'(pready[d]), 32'd0);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        waited = 0;
        done = 0;
        while (!done && waited <= 20) begin
            @(negedge clk);
            if (pready[d]) begin
                done = 1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL %s_sb: got pready with empty scoreboard, expected none", name);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_pslverr"}, 32'(pslverr[d]), 32'(e.err));
                    checkOutput({e.name, "_prdata"}, prdata[d], e.data);
                    checkOutput({e.name, "_waits"}, 32'(waited), (d == 0) ? 32'd0 : 32'd3);
                end
            end else begin
                waited++;
            end
        end
        if (!done) begin
            checks++; errors++;
            sb.delete();
            $display("[TB] FAIL %s_timeout: got no pready in 21 cycles, expected pready", name);
        end
    endtask

    task automatic busIdle(input int d);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic abortWrite(input logic [31:0] addr, input logic [31:0] data);
        int sawReady;
        sawReady = 0;
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = addr; pwdata[1] = data;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        if (pready[1]) sawReady++;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pready[1]) sawReady++;
        end
        checkOutput("abort_no_pready", 32'(sawReady), 32'd0);
    endtask

    // Reset lands mid completion cycle; outputs must drop before the next edge.
    task automatic resetDuringCompletion(input logic [31:0] addr, input logic expErr,
                                         input logic [31:0] expData, input string name);
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = addr;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(negedge clk);
        checkOutput({name, "_pre_pready"}, 32'(pready[0]), 32'd1);
        checkOutput({name, "_pre_pslverr"}, 32'(pslverr[0]), 32'(expErr));
        checkOutput({name, "_pre_prdata"}, prdata[0], expData);
        #1 preset_n = 1'b0;
        #1;
        checkOutput({name, "_rst_pready"}, 32'(pready[0]), 32'd0);
        checkOutput({name, "_rst_pslverr"}, 32'(pslverr[0]), 32'd0);
        checkOutput({name, "_rst_prdata"}, prdata[0], 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        preset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        preset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            paddr[d] = '0; pwrite[d] = 1'b0; psel[d] = 1'b0;
            penable[d] = 1'b0; pwdata[d] = '0;
        end

        vecs.push_back('{1'b0, 32'h00, 32'h0,        1'b0, ID,           "rd_id"});
        vecs.push_back('{1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0,        "wr_08"});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF, "rd_08"});
        vecs.push_back('{1'b1, 32'h02, 32'h12345678, 1'b1, 32'h0,        "wr_misalign_02"});
        vecs.push_back('{1'b1, 32'h06, 32'h12345678, 1'b1, 32'h0,        "wr_misalign_06"});
        vecs.push_back('{1'b0, 32'h04, 32'h0,        1'b0, 32'h0,        "rd_04_unchanged"});
        vecs.push_back('{1'b0, 32'h40, 32'h0,        1'b1, 32'h0,        "rd_oor_40"});
        vecs.push_back('{1'b1, 32'h00, 32'hFFFFFFFF, 1'b1, 32'h0,        "wr_id"});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        1'b0, ID,           "rd_id_kept"});
        vecs.push_back('{1'b1, 32'h3C, 32'h0F0F0F0F, 1'b0, 32'h0,        "wr_last"});
        vecs.push_back('{1'b0, 32'h3C, 32'h0,        1'b0, 32'h0F0F0F0F, "rd_last"});
        vecs.push_back('{1'b0, 32'h3E, 32'h0,        1'b1, 32'h0,        "rd_misalign_3e"});
        vecs.push_back('{1'b1, 32'h04, 32'h11112222, 1'b0, 32'h0,        "wr_04"});
        vecs.push_back('{1'b0, 32'h04, 32'h0,        1'b0, 32'h11112222, "rd_04"});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF, "rd_08_kept"});

        #2;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset_pready_%0d", d), 32'(pready[d]), 32'd0);
            checkOutput($sformatf("reset_pslverr_%0d", d), 32'(pslverr[d]), 32'd0);
            checkOutput($sformatf("reset_prdata_%0d", d), prdata[d], 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        preset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].data,
                          vecs[i].expErr, vecs[i].expData, vecs[i].name);
        end
        busIdle(0);

        applyStimulus(1, 1'b1, 32'h04, 32'hAAAA5555, 1'b0, 32'h0, "w3_wr_04");
        applyStimulus(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'hAAAA5555, "w3_rd_04");
        applyStimulus(1, 1'b1, 32'h00, 32'h1, 1'b1, 32'h0, "w3_wr_id");
        busIdle(1);
        abortWrite(32'h0C, 32'h12345678);
        applyStimulus(1, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, "w3_rd_0c_after_abort");
        busIdle(1);

        resetDuringCompletion(32'h08, 1'b0, 32'hDEADBEEF, "rst_rd");
        resetDuringCompletion(32'h40, 1'b1, 32'h0, "rst_err");
        applyStimulus(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, "post_rst_rd_08");
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 1'b0, ID, "post_rst_rd_id");
        applyStimulus(0, 1'b1, 32'h10, 32'h5A5A5A5A, 1'b0, 32'h0, "post_rst_wr_10");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h5A5A5A5A, "post_rst_rd_10");
        busIdle(0);
        applyStimulus(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, "w3_post_rst_rd_04");
        busIdle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
